gate_stim_seq: RTL and testbench
================================

GATE_STIM_SEQ -- requirements
Module: gate_stim_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, as already decided.
REQ-002 Parameter HOLD_CYCLES SHALL default to 50 and SHALL set the number of clock cycles each input pattern is held; legal values are 2..1023.
REQ-003 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  SHALL be the synchronous active-high reset.
REQ-005 Port start  input  1  SHALL be the run request, sampled only in IDLE.
REQ-006 Ports a, b  output  1 each  SHALL be the stimulus driven into the downstream AND/OR/NOT gate stage.
REQ-007 Port y_in  input  3  SHALL be the gate-stage result: [2] AND, [1] OR, [0] NOT a.
REQ-008 Port pat_idx  output  2  SHALL be the current pattern index; {a,b} equals pat_idx while running.
REQ-009 Port busy  output  1  SHALL be high in HOLD.
REQ-010 Port done  output  1  SHALL be a one-cycle pulse when the sequence completes.
REQ-011 Port err_cnt  output  3  SHALL be the mismatch count for the last run (0..4).
REQ-012 Port err_flag  output  1  SHALL be high when err_cnt is non-zero.

Function
REQ-013 The FSM SHALL have three states: IDLE, HOLD and DONE.
REQ-014 In IDLE, a=b=0, pat_idx=0, busy=0 and done=0; err_cnt and err_flag SHALL hold the result of the previous run.
REQ-015 IDLE with start=1 SHALL move to HOLD on the next edge, with pat_idx=0, hold counter=0 and err_cnt cleared to 0.
REQ-016 In HOLD, the hold counter SHALL increment every cycle and {a,b} SHALL be registered outputs equal to pat_idx (00, 01, 10, 11 in order).
REQ-017 When the hold counter reaches HOLD_CYCLES-1, the block SHALL sample y_in and compare it against expected = {a&b, a|b, ~a} for the current pattern.
REQ-018 On that final hold cycle with pat_idx<3, pat_idx SHALL increment and the counter SHALL return to 0 on the next edge.
REQ-019 On that final hold cycle with pat_idx==3, the FSM SHALL go to DONE.
REQ-020 Pattern-to-pattern transitions SHALL insert no idle cycles, so every pattern is driven for exactly HOLD_CYCLES cycles.
REQ-021 DONE SHALL last exactly one cycle, with done=1, a=b=0 and busy=0, and SHALL then return to IDLE.
REQ-022 start SHALL be ignored in HOLD and DONE; a start asserted in the same cycle as DONE SHALL not restart the sequence.
REQ-023 A held-high start SHALL begin a new run on every IDLE cycle (back-to-back runs separated by DONE and one IDLE cycle).
REQ-024 err_cnt SHALL saturate at 4 and never wrap.
REQ-025 The hold counter width SHALL be $clog2(HOLD_CYCLES).

Reset
REQ-026 rst SHALL force state IDLE, a=b=0, pat_idx=0, counter=0, busy=0, done=0, err_cnt=0 and err_flag=0 on the next edge, including mid-run.
REQ-027 rst SHALL take priority over start in the same cycle.

Configuration
REQ-028 When macro GATE_STIM_SEQ_CHECK_EN is defined, the y_in comparison and error counting SHALL be active as specified.
REQ-029 When GATE_STIM_SEQ_CHECK_EN is undefined, y_in SHALL be ignored, err_cnt SHALL be tied to 0 and err_flag SHALL be tied to 0; sequencing, busy and done SHALL be unchanged.

Structure
REQ-030 A shared package gate_pkg SHALL hold the state enum (IDLE/HOLD/DONE), the NUM_PATTERNS=4 constant and the expected-result function for {a,b}.
REQ-031 The comparison logic SHALL be one sub-module, gate_resp_chk (inputs a, b, y_in; output mismatch), instantiated only under GATE_STIM_SEQ_CHECK_EN.
REQ-032 The block SHALL be composable with the existing gates stage: a/b to its inputs and its y to y_in.

Verification
REQ-033 With HOLD_CYCLES=50, a correct gate stage and one start pulse, {a,b} SHALL step 00,01,10,11 for 50 cycles each, done SHALL pulse at cycle 201, and err_cnt SHALL be 0.
REQ-034 With y_in[2] stuck at 0, the run SHALL end with err_cnt=1 (pattern 11 only) and err_flag=1.
REQ-035 With y_in forced to 3'b000 on all patterns, err_cnt SHALL end at 4 (saturated boundary) with err_flag=1.
REQ-036 With rst asserted at cycle 120 of a run, all outputs SHALL read reset values on the next edge, and a later start SHALL run cleanly from pattern 00.
REQ-037 With start held high for 3 runs and HOLD_CYCLES=2, the bench SHALL see a done pulse every 10 cycles, and start pulses during HOLD SHALL have no effect.
REQ-038 Compiled without GATE_STIM_SEQ_CHECK_EN and with y_in=3'b000, err_cnt SHALL stay 0 and the sequence timing SHALL match REQ-033.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared types and helpers for the gate stimulus sequencer: FSM states,
// the pattern count and the reference response of the AND/OR/NOT stage.
package gate_pkg;

    localparam int NUM_PATTERNS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } gate_state_e;

    // Result the downstream stage should produce: [2] AND, [1] OR, [0] NOT a.
    function automatic logic [2:0] gate_expected(input logic a, input logic b);
        return {a & b, a | b, ~a};
    endfunction

endpackage

// File: rtl/gate_stim_seq_if.sv
// Control, stimulus and result signals of the gate stimulus sequencer.
// master = requester / gate-stage side, slave = the sequencer itself.
interface gate_stim_seq_if;

    logic       start;
    logic       a;
    logic       b;
    logic [2:0] y_in;
    logic [1:0] pat_idx;
    logic       busy;
    logic       done;
    logic [2:0] err_cnt;
    logic       err_flag;

    modport master (
        output start, y_in,
        input  a, b, pat_idx, busy, done, err_cnt, err_flag
    );

    modport slave (
        input  start, y_in,
        output a, b, pat_idx, busy, done, err_cnt, err_flag
    );

endinterface

// File: rtl/gate_resp_chk.sv
// Compares the gate-stage response against the reference for the current
// stimulus; used only when GATE_STIM_SEQ_CHECK_EN is defined.
module gate_resp_chk
    import gate_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [2:0] y_in,
    output logic       mismatch
);

    assign mismatch = (y_in != gate_expected(a, b));

endmodule

// File: rtl/gate_stim_seq.sv
// Steps {a,b} through 00,01,10,11, holding each for HOLD_CYCLES clocks, and
// counts gate-stage mismatches. Response checking is built only when
// GATE_STIM_SEQ_CHECK_EN is defined; otherwise err_cnt/err_flag stay 0.
module gate_stim_seq
    import gate_pkg::*;
#(
    parameter int HOLD_CYCLES = 50
) (
    input  logic            clk,
    input  logic            rst,
    gate_stim_seq_if.slave  bus
);

    localparam int               CNT_W    = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [1:0]       PAT_LAST = 2'(NUM_PATTERNS - 1);
    localparam logic [2:0]       ERR_MAX  = 3'(NUM_PATTERNS);

    gate_state_e      state_q, state_d;
    logic [1:0]       pat_q, pat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic [2:0]       err_q, err_d;
    logic             mismatch;

`ifdef GATE_STIM_SEQ_CHECK_EN
    gate_resp_chk u_chk (
        .a        (a_q),
        .b        (b_q),
        .y_in     (bus.y_in),
        .mismatch (mismatch)
    );
`else
    logic unused_y_in;
    assign unused_y_in = ^bus.y_in;
    assign mismatch    = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                pat_d = 2'd0;
                cnt_d = '0;
                a_d   = 1'b0;
                b_d   = 1'b0;
                if (bus.start) begin
                    state_d = HOLD;
                    err_d   = 3'd0;
                end
            end

            HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (mismatch && (err_q != ERR_MAX)) begin
                        err_d = err_q + 3'd1;
                    end
                    if (pat_q == PAT_LAST) begin
                        state_d = DONE;
                        pat_d   = 2'd0;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                    end else begin
                        // Next pattern goes out on the very next edge: no gap cycle.
                        pat_d      = pat_q + 2'd1;
                        {a_d, b_d} = pat_q + 2'd1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= 2'd0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            err_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end

    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign bus.pat_idx  = pat_q;
    assign bus.busy     = (state_q == HOLD);
    assign bus.done     = (state_q == DONE);
    assign bus.err_cnt  = err_q;
    assign bus.err_flag = (err_q != 3'd0);

endmodule

// File: tb/tb_gate_stim_seq.sv
// Directed bench: a HOLD_CYCLES=50 instance for sequencing, fault and reset
// runs, and a HOLD_CYCLES=2 instance for back-to-back runs with start held high.
module tb_gate_stim_seq;

`ifdef GATE_STIM_SEQ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst50;
    logic rst2;
    int   mode50;      // 0 good stage, 1 AND stuck at 0, 2 all outputs 0
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    gate_stim_seq_if if50 ();
    gate_stim_seq_if if2 ();

    gate_stim_seq #(.HOLD_CYCLES(50)) u_dut50 (
        .clk (clk),
        .rst (rst50),
        .bus (if50)
    );

    gate_stim_seq #(.HOLD_CYCLES(2)) u_dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (if2)
    );

    // Downstream gate stage models.
    always_comb begin
        case (mode50)
            1:       if50.y_in = {1'b0, if50.a | if50.b, ~if50.a};
            2:       if50.y_in = 3'b000;
            default: if50.y_in = {if50.a & if50.b, if50.a | if50.b, ~if50.a};
        endcase
    end

    assign if2.y_in = {if2.a & if2.b, if2.a | if2.b, ~if2.a};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {pat_idx, a, b, busy, done}
    function automatic logic [31:0] seq50();
        return {26'd0, if50.pat_idx, if50.a, if50.b, if50.busy, if50.done};
    endfunction

    function automatic logic [31:0] seq2();
        return {26'd0, if2.pat_idx, if2.a, if2.b, if2.busy, if2.done};
    endfunction

    function automatic logic [31:0] exp_seq(input logic [1:0] p, input logic busy, input logic done);
        return {26'd0, p, p[1], p[0], busy, done};
    endfunction

    // {pat_idx, a, b, busy, done, err_cnt, err_flag}
    function automatic logic [31:0] all50();
        return {22'd0, if50.pat_idx, if50.a, if50.b, if50.busy, if50.done,
                if50.err_cnt, if50.err_flag};
    endfunction

    task automatic run50(input int mode, input int exp_err, input string name);
        logic [1:0] p;
        mode50     = mode;
        if50.start = 1'b1;
        tick();
        if50.start = 1'b0;
        for (int cyc = 1; cyc <= 201; cyc++) begin
            p = 2'((cyc - 1) / 50);
            if (cyc <= 200) check($sformatf("%s seq c%0d", name, cyc), seq50(), exp_seq(p, 1'b1, 1'b0));
            else            check($sformatf("%s done c%0d", name, cyc), seq50(), exp_seq(2'd0, 1'b0, 1'b1));
            if (cyc == 51 && mode == 2) check($sformatf("%s err after pat0", name), 32'(if50.err_cnt), CHK ? 32'd1 : 32'd0);
            tick();
        end
        check($sformatf("%s idle", name), seq50(), exp_seq(2'd0, 1'b0, 1'b0));
        check($sformatf("%s err_cnt", name), 32'(if50.err_cnt), 32'(exp_err));
        check($sformatf("%s err_flag", name), 32'(if50.err_flag), 32'(exp_err != 0));
        repeat (3) tick();
        check($sformatf("%s err_cnt held", name), 32'(if50.err_cnt), 32'(exp_err));
    endtask

    initial begin
        int ndone;
        rst50      = 1'b1;
        rst2       = 1'b1;
        mode50     = 0;
        if50.start = 1'b0;
        if2.start  = 1'b1;     // reset must win over start
        repeat (3) tick();
        check("reset50 outputs", all50(), 32'd0);
        check("reset2 over start", seq2(), 32'd0);
        rst50 = 1'b0;
        tick();
        check("idle50 after reset", all50(), 32'd0);

        run50(0, 0, "good");
        run50(1, CHK ? 1 : 0, "and_stuck");
        run50(2, CHK ? 4 : 0, "all_zero");

        // Reset at cycle 120 of a faulty run.
        mode50     = 2;
        if50.start = 1'b1;
        tick();
        if50.start = 1'b0;
        repeat (119) tick();
        check("mid seq c120", seq50(), exp_seq(2'd2, 1'b1, 1'b0));
        check("mid err c120", 32'(if50.err_cnt), CHK ? 32'd2 : 32'd0);
        rst50 = 1'b1;
        tick();
        check("mid reset outputs", all50(), 32'd0);
        rst50 = 1'b0;
        tick();
        check("post reset idle", all50(), 32'd0);
        run50(0, 0, "after_rst");

        // Back-to-back runs with HOLD_CYCLES=2 and start held high.
        ndone = 0;
        rst2  = 1'b0;
        tick();
        for (int cyc = 1; cyc <= 31; cyc++) begin
            int r;
            r = (cyc - 1) % 10;
            if (cyc >= 30)   check($sformatf("b2b idle c%0d", cyc), seq2(), exp_seq(2'd0, 1'b0, 1'b0));
            else if (r < 8)  check($sformatf("b2b hold c%0d", cyc), seq2(), exp_seq(2'(r / 2), 1'b1, 1'b0));
            else if (r == 8) check($sformatf("b2b done c%0d", cyc), seq2(), exp_seq(2'd0, 1'b0, 1'b1));
            else             check($sformatf("b2b idle c%0d", cyc), seq2(), exp_seq(2'd0, 1'b0, 1'b0));
            if (if2.done) ndone++;
            if (cyc == 29) if2.start = 1'b0;
            tick();
        end
        check("b2b done count", 32'(ndone), 32'd3);
        check("b2b err_cnt", {28'd0, if2.err_flag, if2.err_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
